// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [3:0] REG_ZERO         = 4'h0;
    localparam int         DRAIN_CYCLES_DEF = 3;
    localparam int         CNT_W_DEF        = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID instruction's sources and the load in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] d_operand1,
    input  logic [3:0] d_operand2,
    input  logic       d_uses_op1,
    input  logic       d_uses_op2,
    input  logic       x_mem_read,
    input  logic [3:0] x_destination,
    output logic       load_use
);

    logic op1_match;
    logic op2_match;

    assign op1_match = d_uses_op1 && (d_operand1 == x_destination);
    assign op2_match = d_uses_op2 && (d_operand2 == x_destination);

    // R0 is hardwired, so a load targeting it can never produce a dependency.
    assign load_use = x_mem_read && (x_destination != REG_ZERO) && (op1_match || op2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage-register sequencer for the 5-stage pipe: stalls, flushes, HLT drain
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_Operand1,
    input  logic [3:0]       D_Operand2,
    input  logic             D_uses_op1,
    input  logic             D_uses_op2,
    input  logic             D_branch_taken,
    input  logic             D_hlt,
    input  logic             X_MemRead,
    input  logic [3:0]       X_Destination,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_wen,
    output logic             fd_wen,
    output logic             fd_flush,
    output logic             dx_wen,
    output logic             dx_flush,
    output logic             xm_wen,
    output logic             mw_wen,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .d_operand1    (D_Operand1),
        .d_operand2    (D_Operand2),
        .d_uses_op1    (D_uses_op1),
        .d_uses_op2    (D_uses_op2),
        .x_mem_read    (X_MemRead),
        .x_destination (X_Destination),
        .load_use      (load_use)
    );

    always_comb begin
        pc_wen      = 1'b1;
        fd_wen      = 1'b1;
        fd_flush    = 1'b0;
        dx_wen      = 1'b1;
        dx_flush    = 1'b0;
        xm_wen      = 1'b1;
        mw_wen      = 1'b1;
        halted      = 1'b0;
        state_d     = state_q;
        drain_d     = drain_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (dmem_stall) begin
                    pc_wen = 1'b0;
                    fd_wen = 1'b0;
                    dx_wen = 1'b0;
                    xm_wen = 1'b0;
                    mw_wen = 1'b0;
                end else if (load_use) begin
                    // Hold PC and IF/ID; the bubble lets the load reach MEM for forwarding.
                    pc_wen   = 1'b0;
                    fd_wen   = 1'b0;
                    dx_flush = 1'b1;
                end else if (D_branch_taken) begin
                    fd_flush = 1'b1;
                end else if (imem_stall) begin
                    pc_wen   = 1'b0;
                    fd_flush = 1'b1;
                end else if (D_hlt) begin
                    pc_wen  = 1'b0;
                    fd_wen  = 1'b0;
                    state_d = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                pc_wen = 1'b0;
                fd_wen = 1'b0;
                if (dmem_stall) begin
                    dx_wen = 1'b0;
                    xm_wen = 1'b0;
                    mw_wen = 1'b0;
                end else begin
                    dx_flush = 1'b1;
                    drain_d  = drain_q - DW'(1);
                    if (drain_q == DW'(1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                pc_wen = 1'b0;
                fd_wen = 1'b0;
                dx_wen = 1'b0;
                xm_wen = 1'b0;
                mw_wen = 1'b0;
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Counters only track RUN-state behaviour; fd_flush is never set outside RUN.
        if (state_q == ST_RUN && !pc_wen) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (fd_flush) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int DRAIN = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       D_Operand1, D_Operand2, X_Destination;
    logic             D_uses_op1, D_uses_op2, D_branch_taken, D_hlt;
    logic             X_MemRead, imem_stall, dmem_stall;
    logic             pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, xm_wen, mw_wen, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .D_Operand1     (D_Operand1),
        .D_Operand2     (D_Operand2),
        .D_uses_op1     (D_uses_op1),
        .D_uses_op2     (D_uses_op2),
        .D_branch_taken (D_branch_taken),
        .D_hlt          (D_hlt),
        .X_MemRead      (X_MemRead),
        .X_Destination  (X_Destination),
        .imem_stall     (imem_stall),
        .dmem_stall     (dmem_stall),
        .pc_wen         (pc_wen),
        .fd_wen         (fd_wen),
        .fd_flush       (fd_flush),
        .dx_wen         (dx_wen),
        .dx_flush       (dx_flush),
        .xm_wen         (xm_wen),
        .mw_wen         (mw_wen),
        .halted         (halted),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: 0 = running, 1 = draining, 2 = halted.
    int m_state, m_drain, m_stall, m_flush;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit lu_now();
        return X_MemRead && (X_Destination != 4'd0) &&
               ((D_uses_op1 && D_Operand1 == X_Destination) ||
                (D_uses_op2 && D_Operand2 == X_Destination));
    endfunction

    // Bits: {pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, xm_wen, mw_wen, halted}
    function automatic logic [7:0] expect_ctl();
        if (m_state == 2) return 8'b0000_0001;
        if (m_state == 1) return dmem_stall ? 8'b0000_0000 : 8'b0001_1110;
        if (dmem_stall)     return 8'b0000_0000;
        if (lu_now())       return 8'b0001_1110;
        if (D_branch_taken) return 8'b1111_0110;
        if (imem_stall)     return 8'b0111_0110;
        if (D_hlt)          return 8'b0001_0110;
        return 8'b1101_0110;
    endfunction

    function automatic logic [7:0] dut_ctl();
        return {pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, xm_wen, mw_wen, halted};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_drain = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_step();
        logic [7:0] e;
        e = expect_ctl();
        if (m_state == 0) begin
            if (!e[7] && m_stall < CMAX) m_stall++;
            if (e[5] && m_flush < CMAX) m_flush++;
            if (!dmem_stall && !lu_now() && !D_branch_taken && !imem_stall && D_hlt) begin
                m_state = 1;
                m_drain = DRAIN;
            end
        end else if (m_state == 1 && !dmem_stall) begin
            m_drain--;
            if (m_drain == 0) m_state = 2;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("ctl", int'(dut_ctl()), int'(expect_ctl()));
        chk("stall_cnt", int'(stall_cnt), m_stall);
        chk("flush_cnt", int'(flush_cnt), m_flush);
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic clear_inputs();
        D_Operand1 = 0; D_Operand2 = 0; X_Destination = 0;
        D_uses_op1 = 0; D_uses_op2 = 0; D_branch_taken = 0; D_hlt = 0;
        X_MemRead = 0; imem_stall = 0; dmem_stall = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int first_halt;
        rst = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        do_reset();

        // Reset state
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);
        chk("rst_ctl", int'(dut_ctl()), 8'hD6);

        // LDW R3 ; ADD R4,R3,R5 -> one bubble
        X_MemRead = 1; X_Destination = 3;
        D_Operand1 = 3; D_uses_op1 = 1; D_Operand2 = 5; D_uses_op2 = 1;
        #1;
        chk("lu_pc_wen", int'(pc_wen), 0);
        chk("lu_fd_wen", int'(fd_wen), 0);
        chk("lu_dx_flush", int'(dx_flush), 1);
        cycle();
        X_MemRead = 0;
        #1;
        chk("after_lu_pc_wen", int'(pc_wen), 1);
        chk("after_lu_stall_cnt", int'(stall_cnt), 1);
        cycle();

        // Load to R0 never hazards; unused source never hazards
        X_MemRead = 1; X_Destination = 0; D_Operand1 = 0; D_uses_op1 = 1;
        #1;
        chk("r0_pc_wen", int'(pc_wen), 1);
        cycle();
        X_Destination = 3; D_Operand1 = 3; D_uses_op1 = 0; D_Operand2 = 3; D_uses_op2 = 0;
        #1;
        chk("nouse_pc_wen", int'(pc_wen), 1);
        cycle();
        chk("nouse_stall_cnt", int'(stall_cnt), 1);

        // Taken branch overrides imem stall
        do_reset();
        D_branch_taken = 1; imem_stall = 1;
        #1;
        chk("br_ctl", int'(dut_ctl()), 8'hF6);
        cycle();
        clear_inputs();
        #1;
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_stall_cnt", int'(stall_cnt), 0);
        cycle();

        // dmem stall coincident with load-use: 4 frozen cycles then one bubble
        do_reset();
        X_MemRead = 1; X_Destination = 3; D_Operand1 = 3; D_uses_op1 = 1; dmem_stall = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz_ctl", int'(dut_ctl()), 0);
            cycle();
        end
        dmem_stall = 0;
        #1;
        chk("bubble_ctl", int'(dut_ctl()), 8'h1E);
        cycle();
        X_MemRead = 0;
        #1;
        chk("frz_stall_cnt", int'(stall_cnt), 5);
        cycle();

        // HLT with two dmem stalls during drain
        do_reset();
        D_hlt = 1;
        #1;
        chk("hlt_ctl", int'(dut_ctl()), 8'h16);
        cycle();
        D_hlt = 0;
        first_halt = 0;
        for (int n = 1; n <= 20; n++) begin
            dmem_stall = (n == 2 || n == 3);
            cycle();
            if (halted && first_halt == 0) first_halt = n;
        end
        dmem_stall = 0;
        chk("halt_latency", first_halt, 5);
        chk("halt_stays", int'(halted), 1);

        // Saturation, then reset in the middle of a drain
        do_reset();
        imem_stall = 1;
        for (int i = 0; i < 20; i++) cycle();
        imem_stall = 0;
        chk("sat_stall_cnt", int'(stall_cnt), 15);
        chk("sat_flush_cnt", int'(flush_cnt), 15);
        D_hlt = 1;
        cycle();
        D_hlt = 0;
        cycle();
        rst = 1'b1;
        #1;
        chk("drain_rst_pc_wen", int'(pc_wen), 1);
        chk("drain_rst_halted", int'(halted), 0);
        chk("drain_rst_stall_cnt", int'(stall_cnt), 0);
        chk("drain_rst_flush_cnt", int'(flush_cnt), 0);
        model_reset();
        cycle();
        rst = 1'b0;

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            if ((m_state == 2 && $urandom_range(0, 9) == 0) || $urandom_range(0, 399) == 0) begin
                do_reset();
            end
            D_Operand1     = 4'($urandom_range(0, 3));
            D_Operand2     = 4'($urandom_range(0, 3));
            X_Destination  = 4'($urandom_range(0, 3));
            D_uses_op1     = 1'($urandom_range(0, 1));
            D_uses_op2     = 1'($urandom_range(0, 1));
            X_MemRead      = ($urandom_range(0, 2) == 0);
            D_branch_taken = ($urandom_range(0, 5) == 0);
            D_hlt          = ($urandom_range(0, 19) == 0);
            imem_stall     = ($urandom_range(0, 4) == 0);
            dmem_stall     = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
